xy2phase_rx: RTL and testbench
==============================

// Module: xy2phase_rx
// PURPOSE
//  Receive-side inverse of the NCO chain: consumes the 12-bit signed X/Y sample pairs
//  (outX/outY with VldX/VldY) the NCO emits, and recovers phase and magnitude.
//  Uses an iterative vectoring-mode CORDIC, one micro-rotation per clock.
//  Used as an on-chip loopback checker and as the front end of a future phase detector.
// PARAMETERS
//  W     12  input sample width, two's complement
//  PW    16  output phase width; full circle = 2^PW (binary angle units)
//  ITER  12  number of vectoring iterations (1..PW-1); sets accuracy and latency
// PORTS
//  clk     in   1     system clock, all logic on rising edge
//  rst     in   1     synchronous reset, active-high
//  VldX    in   1     inX valid this cycle
//  VldY    in   1     inY valid this cycle
//  inX     in   W     X sample (cosine lane), signed
//  inY     in   W     Y sample (sine lane), signed
//  Rdy     out  1     block can accept a sample pair this cycle
//  Vld     out  1     one-cycle pulse: Phase/Mag valid
//  Phase   out  PW    recovered angle, unsigned binary angle, 0 = +X axis, CCW positive
//  Mag     out  W+1   |(x,y)| * K (K~1.6468, not compensated), unsigned
//  ErrSync out  1     sticky: VldX and VldY disagreed in some cycle
//  Ovr     out  1     sticky: sample pair arrived while Rdy=0 (pair dropped)
// BEHAVIOUR
//  Reset: state=IDLE, Rdy=1, Vld=0, Phase=0, Mag=0, ErrSync=0, Ovr=0, count=0. Reset
//   mid-operation aborts the computation; no Vld is produced for the aborted sample.
//  Accept: (VldX & VldY & Rdy) at edge -> sign-extend to W+2 bits, quadrant fold:
//   x<0: x0=-x, y0=-y, z0=2^(PW-1); else x0=x, y0=y, z0=0. count=0, state=ITER.
//  ITER (count i=0..ITER-1), per cycle: d = (y>=0);
//   d: x+=y>>>i, y-=x>>>i, z+=ATAN_LUT[i];  !d: x-=y>>>i, y+=x>>>i, z-=ATAN_LUT[i];
//   x,y use pre-update values; shifts arithmetic; z wraps modulo 2^PW.
//   After i=ITER-1 -> state DONE.
//  DONE: Vld=1 for exactly this cycle; Phase=z, Mag=x[W:0]. Phase/Mag hold until next
//   DONE. Rdy=1 in DONE: a pair arriving in DONE is accepted (back-to-back, no bubble).
//  Latency: pair in cycle 0 -> Vld=1 in cycle ITER+1. Throughput: one pair per ITER+1 cycles.
//  States: IDLE (Rdy=1) -> ITER on accept; ITER (Rdy=0) -> DONE; DONE (Rdy=1) -> ITER on
//   accept, else IDLE.
//  Widths: internal x,y signed W+2 (max 2^(W-1)*sqrt2*K < 2^(W+1)); Mag never negative.
//  Boundaries: (0,0) -> Phase=0, Mag=0; inX=-2^(W-1) negates without overflow (W+2 bits);
//   y=0 counts as d=1; VldX^VldY -> ErrSync=1, pair ignored; pair with Rdy=0 -> Ovr=1,
//   pair ignored, running computation unaffected. Sticky flags clear only on rst.
// STRUCTURE
//  Package nco_pkg: ATAN_LUT[0..PW-2] = round(atan(2^-i)*2^PW/(2*pi)) as PW-bit constants,
//   state enum {IDLE, ITER, DONE}, CORDIC gain constant for bench use.
//  Sub-module cordic_vec_step (combinational): (x,y,z,i) -> (x',y',z'); top holds FSM,
//   counter, registers, flags.
// TESTING (PW=16, ITER=12; phase tol +-8 LSB, mag tol +-4)
//  1 inX=2047,inY=0 after rst -> Vld in cycle 13, Phase~0x0000, Mag~3371
//  2 (0,2047),(-2047,0),(0,-2047) -> Phase~0x4000,0x8000,0xC000; Mag~3371 each
//  3 (-2048,-2048) -> Phase~0xA000, Mag~4770, no overflow; (0,0) -> Phase=0, Mag=0
//  4 pairs every 13 cycles from DONE -> one Vld per pair, Ovr=0; pair during ITER -> Ovr=1,
//    in-flight result unchanged
//  5 VldX=1,VldY=0 one cycle -> ErrSync=1, no Vld; rst in ITER -> no Vld, all outputs 0
//  6 loopback from NCO (FCW=0x01000) -> successive Phase steps of 0x0100 +-8 per NCO sample

Source files
------------

// File: rtl/xy2phase_rx_pkg.sv
// Shared constants, FSM state encoding and the arctangent table used by the
// xy2phase_rx vectoring-mode CORDIC receiver.
package xy2phase_rx_pkg;

    localparam int  XY_W           = 12;
    localparam int  XY_PW          = 16;
    localparam int  XY_ITER        = 12;
    localparam int  XY_CW          = $clog2(XY_PW);
    localparam real XY_CORDIC_GAIN = 1.6467602;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    // atan(2^-i) in binary angle units where the full circle is 2^16
    function automatic logic [XY_PW-1:0] atanLut(input logic [XY_CW-1:0] idx);
        logic [XY_PW-1:0] v;
        case (idx)
            4'd0:    v = 16'd8192;
            4'd1:    v = 16'd4836;
            4'd2:    v = 16'd2555;
            4'd3:    v = 16'd1297;
            4'd4:    v = 16'd651;
            4'd5:    v = 16'd326;
            4'd6:    v = 16'd163;
            4'd7:    v = 16'd81;
            4'd8:    v = 16'd41;
            4'd9:    v = 16'd20;
            4'd10:   v = 16'd10;
            4'd11:   v = 16'd5;
            4'd12:   v = 16'd3;
            4'd13:   v = 16'd1;
            4'd14:   v = 16'd1;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/xy2phase_rx_if.sv
// Sample-pair input and phase/magnitude result bundle of the xy2phase_rx block.
interface xy2phase_rx_if
    import xy2phase_rx_pkg::*;
#(
    parameter int W  = XY_W,
    parameter int PW = XY_PW
);
    logic                VldX;
    logic                VldY;
    logic signed [W-1:0] inX;
    logic signed [W-1:0] inY;
    logic                Rdy;
    logic                Vld;
    logic [PW-1:0]       Phase;
    logic [W:0]          Mag;
    logic                ErrSync;
    logic                Ovr;

    modport master (
        output VldX, VldY, inX, inY,
        input  Rdy, Vld, Phase, Mag, ErrSync, Ovr
    );

    modport slave (
        input  VldX, VldY, inX, inY,
        output Rdy, Vld, Phase, Mag, ErrSync, Ovr
    );

endinterface

// File: rtl/xy2phase_rx_cordic_vec_step.sv
// One combinational vectoring-mode CORDIC micro-rotation: drives y towards zero
// and accumulates the applied rotation into z.
module xy2phase_rx_cordic_vec_step
    import xy2phase_rx_pkg::*;
#(
    parameter int XW = XY_W + 2
) (
    input  logic signed [XW-1:0] i_x,
    input  logic signed [XW-1:0] i_y,
    input  logic [XY_PW-1:0]     i_z,
    input  logic [XY_CW-1:0]     i_idx,
    output logic signed [XW-1:0] o_x,
    output logic signed [XW-1:0] o_y,
    output logic [XY_PW-1:0]     o_z
);
    logic signed [XW-1:0] w_xs;
    logic signed [XW-1:0] w_ys;
    logic [XY_PW-1:0]     w_ang;
    logic                 w_d;

    // y == 0 rotates clockwise, like any non-negative y
    assign w_d   = ~i_y[XW-1];
    assign w_xs  = i_x >>> i_idx;
    assign w_ys  = i_y >>> i_idx;
    assign w_ang = atanLut(i_idx);

    assign o_x = w_d ? (i_x + w_ys) : (i_x - w_ys);
    assign o_y = w_d ? (i_y - w_xs) : (i_y + w_xs);
    assign o_z = w_d ? (i_z + w_ang) : (i_z - w_ang);

endmodule

// File: rtl/xy2phase_rx.sv
// Iterative CORDIC receiver: converts a signed X/Y sample pair into a binary-angle
// phase and an uncompensated magnitude, one micro-rotation per clock.
module xy2phase_rx
    import xy2phase_rx_pkg::*;
#(
    parameter int W    = XY_W,
    parameter int ITER = XY_ITER
) (
    input  logic         clk,
    input  logic         rst,
    xy2phase_rx_if.slave bus
);
    localparam int PW = XY_PW;
    localparam int XW = W + 2;

    state_t               r_state;
    state_t               w_nextState;
    logic signed [XW-1:0] r_x;
    logic signed [XW-1:0] r_y;
    logic signed [XW-1:0] w_xIn;
    logic signed [XW-1:0] w_yIn;
    logic signed [XW-1:0] w_x0;
    logic signed [XW-1:0] w_y0;
    logic signed [XW-1:0] w_nx;
    logic signed [XW-1:0] w_ny;
    logic [PW-1:0]        r_z;
    logic [PW-1:0]        w_z0;
    logic [PW-1:0]        w_nz;
    logic [PW-1:0]        r_phase;
    logic [W:0]           r_mag;
    logic [XY_CW-1:0]     r_count;
    logic                 r_zero;
    logic                 r_errSync;
    logic                 r_ovr;
    logic                 w_rdy;
    logic                 w_vld;
    logic                 w_pair;
    logic                 w_accept;
    logic                 w_lastIter;

    assign w_pair     = bus.VldX & bus.VldY;
    assign w_accept   = w_pair & w_rdy;
    assign w_lastIter = (r_count == XY_CW'(ITER - 1));

    assign w_xIn = {{2{bus.inX[W-1]}}, bus.inX};
    assign w_yIn = {{2{bus.inY[W-1]}}, bus.inY};

    // Left half-plane is rotated by 180 degrees so the iterations only cover +-90 degrees
    assign w_x0 = w_xIn[XW-1] ? -w_xIn : w_xIn;
    assign w_y0 = w_xIn[XW-1] ? -w_yIn : w_yIn;
    assign w_z0 = w_xIn[XW-1] ? {1'b1, {(PW-1){1'b0}}} : '0;

    xy2phase_rx_cordic_vec_step #(
        .XW(XW)
    ) u_step (
        .i_x  (r_x),
        .i_y  (r_y),
        .i_z  (r_z),
        .i_idx(r_count),
        .o_x  (w_nx),
        .o_y  (w_ny),
        .o_z  (w_nz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_nextState = S_ITER;
            S_ITER:  if (w_lastIter) w_nextState = S_DONE;
            S_DONE:  w_nextState = w_accept ? S_ITER : S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdy = 1'b1;
        w_vld = 1'b0;
        case (r_state)
            S_ITER:  w_rdy = 1'b0;
            S_DONE:  w_vld = 1'b1;
            default: ;
        endcase
    end

    // An all-zero input never moves y, so z would pile up every table entry; force 0 instead
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_count   <= '0;
            r_zero    <= 1'b0;
            r_phase   <= '0;
            r_mag     <= '0;
            r_errSync <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x     <= w_x0;
                r_y     <= w_y0;
                r_z     <= w_z0;
                r_count <= '0;
                r_zero  <= (bus.inX == '0) && (bus.inY == '0);
            end else if (r_state == S_ITER) begin
                r_x     <= w_nx;
                r_y     <= w_ny;
                r_z     <= w_nz;
                r_count <= r_count + XY_CW'(1);
            end
            if ((r_state == S_ITER) && w_lastIter) begin
                r_phase <= r_zero ? '0 : w_nz;
                r_mag   <= w_nx[W:0];
            end
            if (bus.VldX ^ bus.VldY) begin
                r_errSync <= 1'b1;
            end
            if (w_pair && !w_rdy) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign bus.Rdy     = w_rdy;
    assign bus.Vld     = w_vld;
    assign bus.Phase   = r_phase;
    assign bus.Mag     = r_mag;
    assign bus.ErrSync = r_errSync;
    assign bus.Ovr     = r_ovr;

endmodule

// File: tb/tb_xy2phase_rx.sv
// Bench for xy2phase_rx: directed and random sample pairs checked against an
// atan2/sqrt reference, plus handshake, sticky-flag and reset behaviour.
module tb_xy2phase_rx;
    import xy2phase_rx_pkg::*;

    localparam int  W      = XY_W;
    localparam int  PW     = XY_PW;
    localparam int  LAT    = XY_ITER + 1;
    localparam int  FULL   = 1 << PW;
    localparam real TWO_PI = 6.283185307179586;

    typedef struct {
        int phase;
        int mag;
        int tolPh;
        int tolMag;
        int cyc;
    } expect_t;

    logic clk = 1'b0;
    logic rst;

    xy2phase_rx_if #(.W(W), .PW(PW)) busIf ();

    xy2phase_rx dut (
        .clk(clk),
        .rst(rst),
        .bus(busIf.slave)
    );

    always #5 clk = ~clk;

    expect_t expQ[$];
    expect_t monExp;
    int      cycleCount = 0;
    int      vldSeen    = 0;
    int      checks     = 0;
    int      errors     = 0;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected,
                               input int tol, input int modulus);
        int diff;
        checks++;
        diff = observed - expected;
        if (modulus > 0) begin
            diff = diff % modulus;
            if (diff < 0) diff += modulus;
            if (diff > modulus / 2) diff -= modulus;
        end
        if (diff > tol || diff < -tol) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", tag, observed, expected, tol);
        end
    endtask

    // Ideal vector angle and length, scaled by the CORDIC gain
    function automatic expect_t refModel(input int x, input int y, input int tolPh, input int tolMag);
        expect_t e;
        real     ang;
        real     rad;
        ang = $atan2(real'(y), real'(x));
        if (ang < 0.0) ang = ang + TWO_PI;
        e.phase  = int'(ang / TWO_PI * real'(FULL)) % FULL;
        rad      = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        e.mag    = int'(rad * XY_CORDIC_GAIN);
        e.tolPh  = tolPh;
        e.tolMag = tolMag;
        e.cyc    = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && busIf.Vld) begin
            vldSeen++;
            if (expQ.size() == 0) begin
                checkOutput("unexpectedVld", 1, 0, 0, 0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("latency", cycleCount - monExp.cyc, LAT, 0, 0);
                checkOutput("phase", int'(busIf.Phase), monExp.phase, monExp.tolPh, FULL);
                checkOutput("mag", int'(busIf.Mag), monExp.mag, monExp.tolMag, 0);
            end
        end
    end

    task automatic applyStimulus(input int x, input int y, input expect_t e);
        int      waitCyc;
        expect_t ent;
        waitCyc = 0;
        @(negedge clk);
        while (!busIf.Rdy && waitCyc < 40) begin
            @(negedge clk);
            waitCyc++;
        end
        if (waitCyc >= 40) checkOutput("rdyTimeout", waitCyc, 0, 0, 0);
        ent     = e;
        ent.cyc = cycleCount;
        expQ.push_back(ent);
        busIf.VldX = 1'b1;
        busIf.VldY = 1'b1;
        busIf.inX  = W'(x);
        busIf.inY  = W'(y);
        @(negedge clk);
        busIf.VldX = 1'b0;
        busIf.VldY = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checkOutput("drain", expQ.size(), 0, 0, 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        expQ.delete();
        @(negedge clk);
        checkOutput("rstRdy", int'(busIf.Rdy), 1, 0, 0);
        checkOutput("rstVld", int'(busIf.Vld), 0, 0, 0);
        checkOutput("rstPhase", int'(busIf.Phase), 0, 0, 0);
        checkOutput("rstMag", int'(busIf.Mag), 0, 0, 0);
        checkOutput("rstErrSync", int'(busIf.ErrSync), 0, 0, 0);
        checkOutput("rstOvr", int'(busIf.Ovr), 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int      x;
        int      y;
        int      acc;
        int      vldBefore;
        real     th;
        real     r;
        expect_t e;

        rst        = 1'b1;
        busIf.VldX = 1'b0;
        busIf.VldY = 1'b0;
        busIf.inX  = '0;
        busIf.inY  = '0;
        repeat (2) @(negedge clk);
        doReset();

        $display("[TB] axis and diagonal vectors");
        applyStimulus(2047, 0, refModel(2047, 0, 8, 6));
        waitDrain();
        applyStimulus(0, 2047, refModel(0, 2047, 8, 6));
        applyStimulus(-2047, 0, refModel(-2047, 0, 8, 6));
        applyStimulus(0, -2047, refModel(0, -2047, 8, 6));
        applyStimulus(-2048, -2048, refModel(-2048, -2048, 8, 6));
        applyStimulus(0, 0, refModel(0, 0, 0, 0));
        waitDrain();

        // Pairs issued as soon as Rdy allows land in the DONE cycle, i.e. back-to-back
        $display("[TB] back-to-back pairs");
        for (int k = 0; k < 4; k++) begin
            th = TWO_PI * real'($urandom_range(0, 65535)) / 65536.0;
            r  = 1700.0 + real'($urandom_range(0, 340));
            x  = int'(r * $cos(th));
            y  = int'(r * $sin(th));
            applyStimulus(x, y, refModel(x, y, 24, 10));
        end
        waitDrain();
        checkOutput("ovrAfterB2B", int'(busIf.Ovr), 0, 0, 0);
        checkOutput("errSyncAfterB2B", int'(busIf.ErrSync), 0, 0, 0);

        $display("[TB] pair dropped during iteration");
        vldBefore = vldSeen;
        applyStimulus(1000, 1500, refModel(1000, 1500, 8, 6));
        repeat (3) @(negedge clk);
        busIf.VldX = 1'b1;
        busIf.VldY = 1'b1;
        busIf.inX  = W'(-500);
        busIf.inY  = W'(300);
        @(negedge clk);
        busIf.VldX = 1'b0;
        busIf.VldY = 1'b0;
        waitDrain();
        repeat (LAT + 2) @(negedge clk);
        checkOutput("ovrSet", int'(busIf.Ovr), 1, 0, 0);
        checkOutput("ovrVldCount", vldSeen - vldBefore, 1, 0, 0);

        $display("[TB] reset during iteration");
        applyStimulus(1200, -900, refModel(1200, -900, 8, 6));
        repeat (5) @(negedge clk);
        vldBefore = vldSeen;
        doReset();
        repeat (LAT + 5) @(negedge clk);
        checkOutput("abortNoVld", vldSeen - vldBefore, 0, 0, 0);

        $display("[TB] unsynchronised valids");
        vldBefore  = vldSeen;
        busIf.VldX = 1'b1;
        busIf.VldY = 1'b0;
        busIf.inX  = W'(700);
        busIf.inY  = W'(700);
        @(negedge clk);
        busIf.VldX = 1'b0;
        repeat (LAT + 5) @(negedge clk);
        checkOutput("errSyncSet", int'(busIf.ErrSync), 1, 0, 0);
        checkOutput("errSyncNoVld", vldSeen - vldBefore, 0, 0, 0);
        doReset();

        $display("[TB] NCO loopback, FCW 0x01000");
        acc = 'h0F000;
        for (int k = 0; k < 6; k++) begin
            th      = TWO_PI * real'(acc) / 1048576.0;
            x       = int'(2047.0 * $cos(th));
            y       = int'(2047.0 * $sin(th));
            e       = refModel(x, y, 12, 6);
            e.phase = (acc >> 4) & (FULL - 1);
            applyStimulus(x, y, e);
            acc = (acc + 'h01000) & 'hFFFFF;
        end
        waitDrain();

        $display("[TB] random vectors with gaps");
        for (int k = 0; k < 10; k++) begin
            th = TWO_PI * real'($urandom_range(0, 65535)) / 65536.0;
            r  = 1700.0 + real'($urandom_range(0, 340));
            x  = int'(r * $cos(th));
            y  = int'(r * $sin(th));
            applyStimulus(x, y, refModel(x, y, 24, 10));
            repeat ($urandom_range(0, 15)) @(negedge clk);
        end
        waitDrain();
        checkOutput("ovrFinal", int'(busIf.Ovr), 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
